// File: rtl/branch_verify_pkg.sv
// Shared CPU types for the branch verification unit.
// Holds the BHT entry and verify_result structs, the control-transfer codes,
// the FSM state encoding, and the resolution helpers.
package branch_verify_pkg;

    localparam int XLEN = 32;

    // Control-transfer classes; 0 marks an instruction that is not a branch.
    localparam logic [2:0] B_IS_NONE = 3'd0;
    localparam logic [2:0] B_IS_CALL = 3'd1;
    localparam logic [2:0] B_IS_RET  = 3'd2;
    localparam logic [2:0] B_IS_BRA  = 3'd3;
    localparam logic [2:0] B_IS_J    = 3'd4;

    // Predictor state that was read at fetch and travels down with the branch.
    typedef struct packed {
        logic [1:0] sat_cnt;
        logic [5:0] history;
    } BHT_entry_t;

    // One update for the fetch-side predictor.
    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] pc;
        logic [2:0]      br_type;
        logic            is_taken;
        logic            predict_sucess;
        logic [XLEN-1:0] correct_target;
        BHT_entry_t      predict_entry;
    } verify_result_t;

    typedef enum logic [1:0] {
        BV_IDLE    = 2'd0,
        BV_WAIT_DS = 2'd1,
        BV_ISSUE   = 2'd2,
        BV_HOLD    = 2'd3
    } bv_state_t;

    // Address the fetch stage should have gone to; the fall-through skips the delay slot.
    function automatic logic [XLEN-1:0] resolve_target(
        input logic [XLEN-1:0] pc,
        input logic            is_taken,
        input logic [XLEN-1:0] target
    );
        return is_taken ? target : pc + 32'd8;
    endfunction

    // Direction must match; the target only matters when the branch was taken.
    function automatic logic prediction_ok(
        input logic            pred_taken,
        input logic            is_taken,
        input logic [XLEN-1:0] pred_target,
        input logic [XLEN-1:0] target
    );
        return (pred_taken == is_taken) && (!is_taken || (pred_target == target));
    endfunction

endpackage

// File: rtl/branch_verify_sat_wrap_counter.sv
// Free-running statistics counter that wraps at 2^W.
module sat_wrap_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count one event per enabled cycle; overflow wraps back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_verify.sv
// Execute-stage branch verification unit.
// Accepts one resolved branch at a time, judges the fetch-time prediction,
// holds mispredict reports until the delay slot is in decode, and emits a
// single-cycle verify_result pulse followed by a quiet cycle after a mispredict.
module branch_verify
    import branch_verify_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipeline_flush,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [2:0]          ex_br_type,
    input  logic                ex_is_taken,
    input  logic [XLEN-1:0]     ex_target,
    input  logic                ex_pred_taken,
    input  logic [XLEN-1:0]     ex_pred_target,
    input  BHT_entry_t          ex_predict_entry,
    input  logic                ds_valid,
    output verify_result_t      verify_result,
    output logic [CNT_W-1:0]    br_cnt,
    output logic [CNT_W-1:0]    mispred_cnt
);

    bv_state_t      state_q;
    verify_result_t data_q;     // branch captured at acceptance, ready bit unused
    verify_result_t data_d;
    verify_result_t result_q;   // registered predictor update, non-zero only in ISSUE
    logic           accept;
    logic           issue_fire;

    assign ex_ready = (state_q == BV_IDLE) && !pipeline_flush;
    assign accept   = ex_valid && ex_ready && (ex_br_type != B_IS_NONE);

    // Resolve the incoming branch so only finished results get latched.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        data_d                = '0;
        data_d.pc             = ex_pc;
        data_d.br_type        = ex_br_type;
        data_d.is_taken       = ex_is_taken;
        data_d.predict_sucess = prediction_ok(ex_pred_taken, ex_is_taken, ex_pred_target, ex_target);
        data_d.correct_target = resolve_target(ex_pc, ex_is_taken, ex_target);
        data_d.predict_entry  = ex_predict_entry;
    end

    // Verification FSM; the result register is loaded on the edge that enters ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BV_IDLE;
            data_q   <= '0;
            result_q <= '0;
        end else if (pipeline_flush) begin
            state_q  <= BV_IDLE;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            result_q <= '0;
            unique case (state_q)
                BV_IDLE: begin
                    if (accept) begin
                        data_q <= data_d;
                        if (data_d.predict_sucess || ds_valid) begin
                            state_q        <= BV_ISSUE;
                            result_q       <= data_d;
                            result_q.ready <= 1'b1;
                        end else begin
                            state_q <= BV_WAIT_DS;
                        end
                    end
                end
                BV_WAIT_DS: begin
                    if (ds_valid) begin
                        state_q        <= BV_ISSUE;
                        result_q       <= data_q;
                        result_q.ready <= 1'b1;
                    end
                end
                BV_ISSUE: begin
                    state_q <= data_q.predict_sucess ? BV_IDLE : BV_HOLD;
                    data_q  <= '0;
                end
                BV_HOLD: begin
                    state_q <= BV_IDLE;
                end
            endcase
        end
    end

    // A flush in the ISSUE cycle cancels the branch, so the predictor must not see it either.
    assign verify_result = pipeline_flush ? '0 : result_q;

    assign issue_fire = (state_q == BV_ISSUE) && !pipeline_flush;

    sat_wrap_counter #(.W(CNT_W)) u_br_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (issue_fire),
        .count_o (br_cnt)
    );

    sat_wrap_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (issue_fire && !data_q.predict_sucess),
        .count_o (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_verify.sv
// Directed self-checking bench for branch_verify.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_branch_verify;
    import branch_verify_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           pipeline_flush;
    logic           ex_valid;
    logic           ex_ready;
    logic [31:0]    ex_pc;
    logic [2:0]     ex_br_type;
    logic           ex_is_taken;
    logic [31:0]    ex_target;
    logic           ex_pred_taken;
    logic [31:0]    ex_pred_target;
    BHT_entry_t     ex_predict_entry;
    logic           ds_valid;
    verify_result_t verify_result;
    logic [31:0]    br_cnt;
    logic [31:0]    mispred_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_br = 0;
    int exp_mis = 0;

    branch_verify #(.CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipeline_flush   (pipeline_flush),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_pc            (ex_pc),
        .ex_br_type       (ex_br_type),
        .ex_is_taken      (ex_is_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_predict_entry (ex_predict_entry),
        .ds_valid         (ds_valid),
        .verify_result    (verify_result),
        .br_cnt           (br_cnt),
        .mispred_cnt      (mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid         = 1'b0;
        ex_pc            = '0;
        ex_br_type       = B_IS_NONE;
        ex_is_taken      = 1'b0;
        ex_target        = '0;
        ex_pred_taken    = 1'b0;
        ex_pred_target   = '0;
        ex_predict_entry = '0;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic [2:0] bt, input logic taken,
                            input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
                            input logic [7:0] entry);
        ex_valid         = 1'b1;
        ex_pc            = pc;
        ex_br_type       = bt;
        ex_is_taken      = taken;
        ex_target        = tgt;
        ex_pred_taken    = ptaken;
        ex_pred_target   = ptgt;
        ex_predict_entry = entry;
    endtask

    task automatic check_ready(input string name, input logic exp);
        @(negedge clk);
        if (verify_result.ready !== exp) begin
            n_bad++; $display("FAIL %s.ready: got %b want %b", name, verify_result.ready, exp);
        end
        n_cmp++;
    endtask

    task automatic check_counts(input string name);
        if (br_cnt !== 32'(exp_br)) begin
            n_bad++; $display("FAIL %s.br_cnt: got %0d want %0d", name, br_cnt, exp_br);
        end
        n_cmp++;
        if (mispred_cnt !== 32'(exp_mis)) begin
            n_bad++; $display("FAIL %s.mispred_cnt: got %0d want %0d", name, mispred_cnt, exp_mis);
        end
        n_cmp++;
    endtask

    task automatic check_ex_ready(input string name, input logic exp);
        if (ex_ready !== exp) begin
            n_bad++; $display("FAIL %s.ex_ready: got %b want %b", name, ex_ready, exp);
        end
        n_cmp++;
    endtask

    task automatic test_reset();
        #12;
        if (verify_result !== '0) begin
            n_bad++; $display("FAIL reset.verify_result: got %h want 0", verify_result);
        end
        n_cmp++;
        check_counts("reset");
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_ex_ready("reset", 1'b1);
        next_cycle();
    endtask

    // BRA 0x1000 -> 0x2000, predicted correctly, delay slot present.
    task automatic test_correct_taken(input string name);
        drive_br(32'h1000, B_IS_BRA, 1'b1, 32'h2000, 1'b1, 32'h2000, 8'hA5);
        ds_valid = 1'b1;
        @(negedge clk);
        check_ex_ready(name, 1'b1);
        next_cycle();
        drive_idle();
        ds_valid = 1'b0;
        check_ready(name, 1'b1);
        if (verify_result.predict_sucess !== 1'b1 || verify_result.correct_target !== 32'h2000 ||
            verify_result.pc !== 32'h1000 || verify_result.br_type !== B_IS_BRA ||
            verify_result.is_taken !== 1'b1 || verify_result.predict_entry !== 8'hA5) begin
            n_bad++;
            $display("FAIL %s.fields: got ok=%b tgt=%h pc=%h type=%0d tk=%b ent=%h want ok=1 tgt=2000 pc=1000 type=3 tk=1 ent=a5",
                     name, verify_result.predict_sucess, verify_result.correct_target, verify_result.pc,
                     verify_result.br_type, verify_result.is_taken, verify_result.predict_entry);
        end
        n_cmp++;
        check_ex_ready(name, 1'b0);
        next_cycle();
        exp_br++;
        check_ready(name, 1'b0);
        check_ex_ready(name, 1'b1);
        check_counts(name);
        next_cycle();
    endtask

    // Not taken but predicted taken; delay slot arrives four cycles after acceptance.
    task automatic test_dir_mispredict_late_ds();
        drive_br(32'h1000, B_IS_BRA, 1'b0, 32'h1040, 1'b1, 32'h1040, 8'h3C);
        ds_valid = 1'b0;
        next_cycle();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            check_ready("late_ds.wait", 1'b0);
            check_ex_ready("late_ds.wait", 1'b0);
            next_cycle();
        end
        ds_valid = 1'b1;
        check_ready("late_ds.ds", 1'b0);
        next_cycle();
        ds_valid = 1'b0;
        check_ready("late_ds.issue", 1'b1);
        if (verify_result.predict_sucess !== 1'b0 || verify_result.correct_target !== 32'h1008 ||
            verify_result.is_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL late_ds.fields: got ok=%b tgt=%h tk=%b want ok=0 tgt=1008 tk=0",
                     verify_result.predict_sucess, verify_result.correct_target, verify_result.is_taken);
        end
        n_cmp++;
        next_cycle();
        exp_br++; exp_mis++;
        check_ready("late_ds.hold", 1'b0);
        check_ex_ready("late_ds.hold", 1'b0);
        check_counts("late_ds.hold");
        next_cycle();
        @(negedge clk);
        check_ex_ready("late_ds.idle", 1'b1);
        next_cycle();
    endtask

    // RET taken to 0x3000 but predicted 0x3100; delay slot present at acceptance.
    task automatic test_target_mispredict();
        drive_br(32'h4000, B_IS_RET, 1'b1, 32'h3000, 1'b1, 32'h3100, 8'h11);
        ds_valid = 1'b1;
        next_cycle();
        drive_idle();
        ds_valid = 1'b0;
        check_ready("tgt_mis.issue", 1'b1);
        if (verify_result.predict_sucess !== 1'b0 || verify_result.correct_target !== 32'h3000 ||
            verify_result.br_type !== B_IS_RET) begin
            n_bad++;
            $display("FAIL tgt_mis.fields: got ok=%b tgt=%h type=%0d want ok=0 tgt=3000 type=2",
                     verify_result.predict_sucess, verify_result.correct_target, verify_result.br_type);
        end
        n_cmp++;
        next_cycle();
        exp_br++; exp_mis++;
        check_ready("tgt_mis.hold", 1'b0);
        check_ex_ready("tgt_mis.hold", 1'b0);
        next_cycle();
        @(negedge clk);
        check_ex_ready("tgt_mis.idle", 1'b1);
        check_counts("tgt_mis.idle");
        next_cycle();
    endtask

    // Fall-through address of the last word wraps to 4.
    task automatic test_addr_wrap();
        drive_br(32'hFFFF_FFFC, B_IS_BRA, 1'b0, 32'h0000_0100, 1'b0, 32'h0000_0200, 8'h00);
        ds_valid = 1'b1;
        next_cycle();
        drive_idle();
        ds_valid = 1'b0;
        check_ready("wrap", 1'b1);
        if (verify_result.correct_target !== 32'h0000_0004 || verify_result.predict_sucess !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap.fields: got tgt=%h ok=%b want tgt=00000004 ok=1",
                     verify_result.correct_target, verify_result.predict_sucess);
        end
        n_cmp++;
        next_cycle();
        exp_br++;
        check_ex_ready("wrap", 1'b1);
        check_counts("wrap");
        next_cycle();
    endtask

    // Second branch held valid while the first is issuing; it must wait for IDLE.
    task automatic test_back_to_back();
        drive_br(32'h5000, B_IS_CALL, 1'b1, 32'h6000, 1'b1, 32'h6000, 8'h42);
        ds_valid = 1'b1;
        next_cycle();
        drive_br(32'h5100, B_IS_J, 1'b1, 32'h7000, 1'b1, 32'h7000, 8'h24);
        check_ready("b2b.first", 1'b1);
        check_ex_ready("b2b.first", 1'b0);
        next_cycle();
        exp_br++;
        check_ready("b2b.gap", 1'b0);
        check_ex_ready("b2b.gap", 1'b1);
        next_cycle();
        drive_idle();
        ds_valid = 1'b0;
        check_ready("b2b.second", 1'b1);
        if (verify_result.pc !== 32'h5100 || verify_result.correct_target !== 32'h7000) begin
            n_bad++;
            $display("FAIL b2b.second_fields: got pc=%h tgt=%h want pc=5100 tgt=7000",
                     verify_result.pc, verify_result.correct_target);
        end
        n_cmp++;
        next_cycle();
        exp_br++;
        check_ready("b2b.end", 1'b0);
        check_counts("b2b.end");
        next_cycle();
    endtask

    task automatic test_flush();
        // Flush while waiting for the delay slot.
        drive_br(32'h8000, B_IS_BRA, 1'b1, 32'h8800, 1'b0, 32'h0, 8'h01);
        ds_valid = 1'b0;
        next_cycle();
        drive_idle();
        pipeline_flush = 1'b1;
        @(negedge clk);
        check_ex_ready("flush_wait", 1'b0);
        next_cycle();
        pipeline_flush = 1'b0;
        ds_valid = 1'b1;
        check_ready("flush_wait.after", 1'b0);
        check_ex_ready("flush_wait.after", 1'b1);
        next_cycle();
        ds_valid = 1'b0;
        check_ready("flush_wait.after2", 1'b0);
        check_counts("flush_wait");
        next_cycle();

        // Flush in the ISSUE cycle: branch is dropped, nothing counted.
        drive_br(32'h9000, B_IS_BRA, 1'b1, 32'h9400, 1'b1, 32'h9400, 8'h02);
        ds_valid = 1'b1;
        next_cycle();
        drive_idle();
        ds_valid = 1'b0;
        pipeline_flush = 1'b1;
        next_cycle();
        pipeline_flush = 1'b0;
        check_ready("flush_issue.after", 1'b0);
        check_ex_ready("flush_issue.after", 1'b1);
        check_counts("flush_issue");
        next_cycle();

        // Flush together with a valid branch: no acceptance.
        drive_br(32'hA000, B_IS_BRA, 1'b1, 32'hA400, 1'b1, 32'hA400, 8'h03);
        ds_valid = 1'b1;
        pipeline_flush = 1'b1;
        @(negedge clk);
        check_ex_ready("flush_valid", 1'b0);
        next_cycle();
        drive_idle();
        ds_valid = 1'b0;
        pipeline_flush = 1'b0;
        check_ready("flush_valid.after", 1'b0);
        check_ex_ready("flush_valid.after", 1'b1);
        next_cycle();
        check_ready("flush_valid.after2", 1'b0);
        check_counts("flush_valid");
        next_cycle();
    endtask

    // Non-branch with ex_valid is swallowed without a result.
    task automatic test_non_branch();
        drive_br(32'hB000, B_IS_NONE, 1'b1, 32'hB400, 1'b0, 32'h0, 8'h00);
        ds_valid = 1'b1;
        next_cycle();
        drive_idle();
        ds_valid = 1'b0;
        check_ready("non_branch", 1'b0);
        check_ex_ready("non_branch", 1'b1);
        check_counts("non_branch");
        next_cycle();
    endtask

    // Reset asserted in WAIT_DS clears everything immediately.
    task automatic test_reset_mid();
        drive_br(32'hC000, B_IS_BRA, 1'b0, 32'hC400, 1'b1, 32'hC400, 8'h77);
        ds_valid = 1'b0;
        next_cycle();
        drive_idle();
        @(negedge clk);
        check_ex_ready("rst_mid.wait", 1'b0);
        #1;
        rst = 1'b0;
        #1;
        exp_br = 0; exp_mis = 0;
        if (verify_result !== '0) begin
            n_bad++; $display("FAIL rst_mid.verify_result: got %h want 0", verify_result);
        end
        n_cmp++;
        check_counts("rst_mid");
        check_ex_ready("rst_mid", 1'b1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        test_correct_taken("rst_mid.first");
    endtask

    initial begin
        rst            = 1'b0;
        pipeline_flush = 1'b0;
        ds_valid       = 1'b0;
        drive_idle();
        test_reset();
        test_correct_taken("correct_taken");
        test_dir_mispredict_late_ds();
        test_target_mispredict();
        test_addr_wrap();
        test_back_to_back();
        test_flush();
        test_non_branch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
